svc_rv_sram_arb: RTL

Single-port SRAM arbiter that lets the RV core's instruction fetch port (imem) and load/store port (dmem) share one synchronous SRAM macro in the SRAM-backed SoC. Each cycle it grants at most one requester. The data port has priority, and a bounded-starvation guard protects fetch. It tags each SRAM read so the one-cycle-latency read data is returned to the requester that issued it. It sits between the CPU's memory ports and the SRAM.

---
 rtl/svc_rv_sram_arb_pkg.sv | 13 +
 rtl/svc_rv_sram_arb_stats.sv | 36 +++
 rtl/svc_rv_sram_arb.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/svc_rv_sram_arb_pkg.sv
// Shared types for the single-port SRAM arbiter between the RV core's
// instruction fetch port (imem) and load/store port (dmem).
package svc_rv_sram_arb_pkg;

   // Owner of the SRAM read issued in the previous cycle; it steers the
   // one-cycle-latency read data back to the requester that asked for it.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IMEM = 2'd1,
      OWN_DMEM = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/svc_rv_sram_arb_stats.sv
// Wait-cycle counters for the two requesters of svc_rv_sram_arb.
// Each counter advances on every cycle its requester is valid but not
// granted, and wraps modulo 2^32.
module svc_rv_sram_arb_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_req_valid,
   input  logic        imem_req_ready,
   input  logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] stall_imem_cnt,
   output logic [31:0] stall_dmem_cnt
);

   logic [31:0] stall_imem_cnt_r;
   logic [31:0] stall_dmem_cnt_r;

   // Count denied-request cycles per port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_imem_cnt_r <= 32'd0;
         stall_dmem_cnt_r <= 32'd0;
      end else begin
         if (imem_req_valid && !imem_req_ready) begin
            stall_imem_cnt_r <= stall_imem_cnt_r + 32'd1;
         end
         if (dmem_req_valid && !dmem_req_ready) begin
            stall_dmem_cnt_r <= stall_dmem_cnt_r + 32'd1;
         end
      end
   end

   assign stall_imem_cnt = stall_imem_cnt_r;
   assign stall_dmem_cnt = stall_dmem_cnt_r;

endmodule

// File: rtl/svc_rv_sram_arb.sv
// Single-port SRAM arbiter: imem (fetch) and dmem (load/store) share one
// synchronous SRAM. dmem has priority; imem is force-granted after
// MAX_STARVE consecutive denied cycles. Reads are tagged so the data
// returned one cycle later reaches the port that issued the read.
// Optional build macro SVC_RV_SRAM_ARB_STATS_EN adds the stall counters
// stall_imem_cnt / stall_dmem_cnt.
module svc_rv_sram_arb
   import svc_rv_sram_arb_pkg::*;
#(
   parameter int AW         = 12,
   parameter int DW         = 32,
   parameter int MAX_STARVE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            imem_req_valid,
   output logic            imem_req_ready,
   input  logic [AW-1:0]   imem_req_addr,
   output logic            imem_resp_valid,
   output logic [DW-1:0]   imem_resp_data,
   input  logic            dmem_req_valid,
   output logic            dmem_req_ready,
   input  logic [AW-1:0]   dmem_req_addr,
   input  logic            dmem_req_we,
   input  logic [DW/8-1:0] dmem_req_wstrb,
   input  logic [DW-1:0]   dmem_req_wdata,
   output logic            dmem_resp_valid,
   output logic [DW-1:0]   dmem_resp_data,
   output logic            sram_en,
   output logic            sram_we,
   output logic [AW-1:0]   sram_addr,
   output logic [DW/8-1:0] sram_wstrb,
   output logic [DW-1:0]   sram_wdata,
   input  logic [DW-1:0]   sram_rdata
`ifdef SVC_RV_SRAM_ARB_STATS_EN
   ,
   output logic [31:0]     stall_imem_cnt,
   output logic [31:0]     stall_dmem_cnt
`endif
);

   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam int BW = DW / 8;
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);
   localparam logic [SW-1:0] STARVE_ONE   = SW'(1);

   logic [SW-1:0] starve_cnt_r;
   logic [SW-1:0] starve_cnt_nxt_s;
   logic          grant_imem_s;
   logic          grant_dmem_s;
   rd_owner_t     rd_owner_r;
   rd_owner_t     rd_owner_nxt_s;

   // Grant decision: starvation guard first, then dmem priority, then imem;
   // nothing is granted while reset is asserted.
   always_comb begin
      grant_imem_s = 1'b0;
      grant_dmem_s = 1'b0;
      if (rst) begin
         grant_imem_s = 1'b0;
      end else if (imem_req_valid && (starve_cnt_r == STARVE_LIMIT)) begin
         grant_imem_s = 1'b1;
      end else if (dmem_req_valid) begin
         grant_dmem_s = 1'b1;
      end else if (imem_req_valid) begin
         grant_imem_s = 1'b1;
      end else begin
         grant_imem_s = 1'b0;
      end
   end

   assign imem_req_ready = grant_imem_s;
   assign dmem_req_ready = grant_dmem_s;

   // SRAM command from the granted port; a fetch is always a plain read.
   always_comb begin
      sram_en    = grant_imem_s | grant_dmem_s;
      sram_we    = 1'b0;
      sram_addr  = imem_req_addr;
      sram_wstrb = {BW{1'b0}};
      sram_wdata = {DW{1'b0}};
      if (grant_dmem_s) begin
         sram_we    = dmem_req_we;
         sram_addr  = dmem_req_addr;
         sram_wstrb = dmem_req_wstrb;
         sram_wdata = dmem_req_wdata;
      end else begin
         sram_we    = 1'b0;
      end
   end

   // Starvation counter: counts denied imem cycles, saturating at the limit.
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      if (!imem_req_valid || grant_imem_s) begin
         starve_cnt_nxt_s = {SW{1'b0}};
      end else if (starve_cnt_r != STARVE_LIMIT) begin
         starve_cnt_nxt_s = starve_cnt_r + STARVE_ONE;
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
   end

   // Tag the read issued this cycle; writes and idle cycles carry no response.
   always_comb begin
      rd_owner_nxt_s = OWN_NONE;
      if (grant_imem_s) begin
         rd_owner_nxt_s = OWN_IMEM;
      end else if (grant_dmem_s && !dmem_req_we) begin
         rd_owner_nxt_s = OWN_DMEM;
      end else begin
         rd_owner_nxt_s = OWN_NONE;
      end
   end

   // State registers; reset drops any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= {SW{1'b0}};
         rd_owner_r   <= OWN_NONE;
      end else begin
         starve_cnt_r <= starve_cnt_nxt_s;
         rd_owner_r   <= rd_owner_nxt_s;
      end
   end

   // Route returning read data to its owner, zero on the other port.
   always_comb begin
      imem_resp_valid = (rd_owner_r == OWN_IMEM);
      dmem_resp_valid = (rd_owner_r == OWN_DMEM);
      imem_resp_data  = {DW{1'b0}};
      dmem_resp_data  = {DW{1'b0}};
      if (imem_resp_valid) begin
         imem_resp_data = sram_rdata;
      end else begin
         imem_resp_data = {DW{1'b0}};
      end
      if (dmem_resp_valid) begin
         dmem_resp_data = sram_rdata;
      end else begin
         dmem_resp_data = {DW{1'b0}};
      end
   end

`ifdef SVC_RV_SRAM_ARB_STATS_EN
   svc_rv_sram_arb_stats u_stats (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .stall_imem_cnt (stall_imem_cnt),
      .stall_dmem_cnt (stall_dmem_cnt)
   );
`endif

endmodule
